// File: rtl/bus_pkg.sv
// Types and helpers shared by the bus master FSM and the memory slave.
package bus_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } slave_state_t;

    // A zero length field still moves one beat.
    function automatic logic [31:0] beat_count(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module bus_slave_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/bus_slave_mem.sv
// Burst memory slave: FSM, beat/latency counters, wrapping address incrementer.
// Optional error reporting (io_err) enabled by defining BUS_SLAVE_ERR_EN.
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [ADDR_W-1:0] io_address,
    input  logic [LEN_W-1:0]  io_length,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ready,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rddatavalid,
    output logic              io_busy
`ifdef BUS_SLAVE_ERR_EN
    ,
    output logic              io_err
`endif
);

    slave_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]  r_beats, w_beats_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]        r_lat, w_lat_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_rdv, w_rdv_nxt;
    logic              r_rd_gate;
    logic              w_we, w_re;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [DATA_W-1:0] w_ram_q;

    // Beat address wraps naturally in ADDR_W bits.
    assign w_beat_addr = r_addr + ADDR_W'(r_cnt);

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_beats_nxt = r_beats;
        w_cnt_nxt   = r_cnt;
        w_lat_nxt   = r_lat;
        w_ready_nxt = 1'b0;
        w_rdv_nxt   = 1'b0;
        w_we        = 1'b0;
        w_re        = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_wr || io_rd) begin
                    w_addr_nxt  = io_address;
                    w_beats_nxt = LEN_W'(beat_count(32'(io_length)));
                    w_cnt_nxt   = '0;
                    w_lat_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = io_wr ? WR_BURST : RD_WAIT;
                end
            end
            WR_BURST: begin
                if (!io_wr) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_we = 1'b1;
                    if (r_cnt == r_beats - LEN_W'(1)) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + LEN_W'(1);
                        w_ready_nxt = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                // The ready cycle counts as lat 0; the RAM read for beat 0 is
                // issued on the last wait cycle so data lands with rddatavalid.
                if (r_lat == 3'(RD_LAT)) begin
                    w_re        = 1'b1;
                    w_cnt_nxt   = r_cnt + LEN_W'(1);
                    w_rdv_nxt   = 1'b1;
                    w_state_nxt = RD_BURST;
                end else begin
                    w_lat_nxt = r_lat + 3'd1;
                end
            end
            RD_BURST: begin
                if (r_cnt == r_beats) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_re      = 1'b1;
                    w_cnt_nxt = r_cnt + LEN_W'(1);
                    w_rdv_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_beats   <= '0;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_ready   <= 1'b0;
            r_rdv     <= 1'b0;
            r_rd_gate <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_beats   <= w_beats_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lat     <= w_lat_nxt;
            r_ready   <= w_ready_nxt;
            r_rdv     <= w_rdv_nxt;
            r_rd_gate <= r_rd_gate | w_rdv_nxt;
        end
    end

    bus_slave_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clock   (clock),
        .i_we    (w_we & ~reset),
        .i_waddr (w_beat_addr),
        .i_wdata (io_wdata),
        .i_re    (w_re & ~reset),
        .i_raddr (w_beat_addr),
        .o_rdata (w_ram_q)
    );

    // RAM output register has no reset; mask it until the first read beat.
    assign io_rdata       = r_rd_gate ? w_ram_q : '0;
    assign io_ready       = r_ready;
    assign io_rddatavalid = r_rdv;
    assign io_busy        = (r_state != IDLE);

`ifdef BUS_SLAVE_ERR_EN
    logic w_cmd_err;
    logic r_err, r_err_seen;

    assign w_cmd_err = (r_state == IDLE) && (io_wr || io_rd) &&
                       ((io_wr && io_rd) || (io_length == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_seen <= 1'b0;
        end else begin
            r_err_seen <= r_err_seen | w_cmd_err;
            r_err      <= w_cmd_err | ((r_err_seen | w_cmd_err) && (w_state_nxt == IDLE));
        end
    end

    assign io_err = r_err;
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// Scoreboard bench: two slaves (RD_LAT=1 and RD_LAT=3) share one stimulus stream.
module tb_bus_slave_mem;

    logic        clk = 1'b0;
    logic        reset, wr, rd;
    logic [3:0]  addr, len;
    logic [31:0] wdata;
    logic        rdy1, vld1, busy1, rdy3, vld3, busy3;
    logic [31:0] rd1, rd3;
`ifdef BUS_SLAVE_ERR_EN
    logic        err1, err3;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vecs = 0;
    int miss = 0;
    bit sb_off = 1'b0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t q1[$];
    exp_t q3[$];
    logic [31:0] wbuf[16];
    logic [31:0] ebuf[16];

    bus_slave_mem #(.ADDR_W(4), .DATA_W(32), .LEN_W(4), .RD_LAT(1)) u_dut1 (
        .clock(clk), .reset(reset), .io_wr(wr), .io_rd(rd), .io_address(addr),
        .io_length(len), .io_wdata(wdata), .io_ready(rdy1), .io_rdata(rd1),
        .io_rddatavalid(vld1), .io_busy(busy1)
`ifdef BUS_SLAVE_ERR_EN
        , .io_err(err1)
`endif
    );

    bus_slave_mem #(.ADDR_W(4), .DATA_W(32), .LEN_W(4), .RD_LAT(3)) u_dut3 (
        .clock(clk), .reset(reset), .io_wr(wr), .io_rd(rd), .io_address(addr),
        .io_length(len), .io_wdata(wdata), .io_ready(rdy3), .io_rdata(rd3),
        .io_rddatavalid(vld3), .io_busy(busy3)
`ifdef BUS_SLAVE_ERR_EN
        , .io_err(err3)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every read beat must match the head of its scoreboard, in data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !sb_off) begin
            if (vld1) begin
                if (q1.size() == 0) begin
                    vecs++; miss++;
                    $display("FAIL rd1_unexpected_valid: got rdata %0h with empty scoreboard (cycle %0d)", rd1, cyc);
                end else begin
                    e = q1.pop_front();
                    chk("rd1_data", rd1, e.d);
                    chk("rd1_cycle", 32'(cyc), 32'(e.c));
                end
            end
            if (vld3) begin
                if (q3.size() == 0) begin
                    vecs++; miss++;
                    $display("FAIL rd3_unexpected_valid: got rdata %0h with empty scoreboard (cycle %0d)", rd3, cyc);
                end else begin
                    e = q3.pop_front();
                    chk("rd3_data", rd3, e.d);
                    chk("rd3_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    // Write burst from wbuf; wr is dropped after lim accepted beats.
    task automatic do_wr(input logic [3:0] a, input logic [3:0] l, input int lim, input bit rd_too);
        int k = 0;
        int t = 0;
        int full;
        full = (l == 4'd0) ? 1 : int'(l);
        @(posedge clk); #1;
        wr = 1'b1; rd = rd_too; addr = a; len = l; wdata = wbuf[0];
        while (k < lim && t < 40) begin
            @(negedge clk); t++;
            if (rdy1) begin
                k++;
                chk("wr_ready_cycle", 32'(t), 32'(k + 1));
                chk("wr_ready3", 32'(rdy3), 32'd1);
                @(posedge clk); #1;
                if (k == lim) begin wr = 1'b0; rd = 1'b0; end
                else wdata = wbuf[k];
            end else begin
                @(posedge clk); #1;
            end
        end
        wr = 1'b0; rd = 1'b0;
        chk("wr_beats", 32'(k), 32'(lim));
        if (lim < full) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("wr_end_ready", 32'(rdy1), 32'd0);
        chk("wr_end_busy1", 32'(busy1), 32'd0);
        chk("wr_end_busy3", 32'(busy3), 32'd0);
    endtask

    // Read burst; expected beats come from ebuf.
    task automatic do_rd(input logic [3:0] a, input logic [3:0] l);
        int t = 0;
        int n;
        int c;
        n = (l == 4'd0) ? 1 : int'(l);
        @(posedge clk); #1;
        rd = 1'b1; addr = a; len = l;
        do begin @(negedge clk); t++; end while (!rdy1 && t < 20);
        chk("rd_ready_lat", 32'(t), 32'd2);
        chk("rd_ready3", 32'(rdy3), 32'd1);
        c = cyc;
        for (int i = 0; i < n; i++) begin
            q1.push_back(exp_t'{ebuf[i], c + 2 + i});
            q3.push_back(exp_t'{ebuf[i], c + 4 + i});
        end
        @(posedge clk); #1 rd = 1'b0;
        @(negedge clk);
        chk("rd_ready_pulse", 32'(rdy1), 32'd0);
        t = 0;
        while ((q1.size() > 0 || q3.size() > 0) && t < 40) begin @(negedge clk); t++; end
        chk("rd_drain", 32'(q1.size() + q3.size()), 32'd0);
        q1.delete(); q3.delete();
        @(negedge clk);
        chk("rd_end_busy1", 32'(busy1), 32'd0);
        chk("rd_end_busy3", 32'(busy3), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; len = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy1), 32'd0);
        chk("rst_valid", 32'(vld1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_rdata", rd1, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // single word write/read
        wbuf[0] = 32'hA;
        do_wr(4'd4, 4'd1, 1, 1'b0);
        ebuf[0] = 32'hA;
        do_rd(4'd4, 4'd1);

        // wrapping burst across the top of memory
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_wr(4'd14, 4'd4, 4, 1'b0);
        ebuf[0] = 32'd1; ebuf[1] = 32'd2; ebuf[2] = 32'd3; ebuf[3] = 32'd4;
        do_rd(4'd14, 4'd4);

        // reset for two cycles in the middle of a read burst
        sb_off = 1'b1;
        @(posedge clk); #1 rd = 1'b1; addr = 4'd14; len = 4'd4;
        t = 0;
        do begin @(negedge clk); t++; end while (!rdy1 && t < 20);
        @(posedge clk); #1 rd = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!vld1 && t < 20);
        chk("rst_mid_burst_reached", 32'(vld1), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(rdy1), 32'd0);
        chk("rst_mid_valid", 32'(vld1), 32'd0);
        chk("rst_mid_busy1", 32'(busy1), 32'd0);
        chk("rst_mid_busy3", 32'(busy3), 32'd0);
        chk("rst_mid_rdata", rd1, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        sb_off = 1'b0;
        do_rd(4'd14, 4'd4);

        // aborted write burst: only the first two beats land
        wbuf[0] = 32'hC2; wbuf[1] = 32'hC3;
        do_wr(4'd2, 4'd2, 2, 1'b0);
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        do_wr(4'd0, 4'd4, 2, 1'b0);
        ebuf[0] = 32'h11; ebuf[1] = 32'h22; ebuf[2] = 32'hC2; ebuf[3] = 32'hC3;
        do_rd(4'd0, 4'd4);

        // wr and rd together with length 0: one write beat, no read
        wbuf[0] = 32'h55; wbuf[1] = 32'h99;
        do_wr(4'd8, 4'd0, 1, 1'b1);
        ebuf[0] = 32'h55;
        do_rd(4'd8, 4'd1);

        // two-beat read: latency checked on both RD_LAT builds
        wbuf[0] = 32'h66; wbuf[1] = 32'h77;
        do_wr(4'd5, 4'd2, 2, 1'b0);
        ebuf[0] = 32'h66; ebuf[1] = 32'h77;
        do_rd(4'd5, 4'd2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
